// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM encoding and parameter helpers.
package spi_pkg;

  // Frame-level FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_t;

  // Sample edge is the rising sck edge when CPOL equals CPHA, falling otherwise
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

  // Bit counter width: enough to index the longer of command and data word
  function automatic int bit_cnt_w(input int cmd_w, input int data_w);
    return $clog2((cmd_w > data_w) ? cmd_w : data_w);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulse outputs.
// Everything resets to 0, so a pin that is already low out of reset never
// produces a falling-edge pulse (a frame in progress is not re-entered).
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the pin through the synchroniser chain plus one history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_slave_mc.sv
// SPI slave with one active-low select per frame: a CMD_W-bit command followed
// by a burst of DATA_W-bit words, any CPOL/CPHA, MSB- or LSB-first.
module spi_slave_mc
  import spi_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CMD_W       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic [CMD_W-1:0]  cmd_data,
  output logic              cmd_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [CNT_W-1:0]  rx_word_cnt,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ack,
  output logic              frame_done,
  output logic              partial_err,
  output logic              tx_underrun
);

  localparam int               BCW         = bit_cnt_w(CMD_W, DATA_W);
  localparam logic             SAMPLE_RISE = sample_on_rise(CPOL != 0, CPHA != 0);
  localparam logic [BCW-1:0]   CMD_LAST    = BCW'(CMD_W - 1);
  localparam logic [BCW-1:0]   DATA_LAST   = BCW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] IDX_MAX     = {CNT_W{1'b1}};

  logic w_sck_sync, w_sck_rise, w_sck_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_sdi, w_sdi_rise, w_sdi_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .rst(rst), .i_async(spi_sck),
    .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .i_async(spi_cs_n),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // sdi goes through the same depth as sck so a sample edge sees its own bit
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi_sync (
    .clk(clk), .rst(rst), .i_async(spi_sdi),
    .o_sync(w_sdi), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
  );

  assign w_unused = ^{w_sck_sync, w_cs_sync, w_sdi_rise, w_sdi_fall};

  spi_state_t        r_state;
  logic [BCW-1:0]    r_bit_cnt;
  logic [CNT_W-1:0]  r_word_idx;
  logic [CMD_W-1:0]  r_cmd_shift;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_sdo, r_sdo_oe;
  logic [CMD_W-1:0]  r_cmd_data;
  logic [DATA_W-1:0] r_rx_data;
  logic [CNT_W-1:0]  r_rx_word_cnt;
  logic              r_cmd_valid, r_rx_valid, r_tx_ack;
  logic              r_frame_done, r_partial_err, r_tx_underrun;

  logic              w_sample, w_shift;
  logic [CMD_W-1:0]  w_cmd_next;
  logic [DATA_W-1:0] w_rx_next;
  logic              w_cmd_done, w_word_done;
  logic              w_tx_bit;
  logic [DATA_W-1:0] w_tx_shifted;

  assign w_sample = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
  assign w_shift  = SAMPLE_RISE ? w_sck_fall : w_sck_rise;

  // MSB-first fills from the bottom, LSB-first fills from the top
  assign w_cmd_next = (MSB_FIRST != 0) ? {r_cmd_shift[CMD_W-2:0], w_sdi}
                                       : {w_sdi, r_cmd_shift[CMD_W-1:1]};
  assign w_rx_next  = (MSB_FIRST != 0) ? {r_rx_shift[DATA_W-2:0], w_sdi}
                                       : {w_sdi, r_rx_shift[DATA_W-1:1]};

  assign w_cmd_done  = (r_state == CMD)  && w_sample && (r_bit_cnt == CMD_LAST);
  assign w_word_done = (r_state == DATA) && w_sample && (r_bit_cnt == DATA_LAST);

  assign w_tx_bit     = (MSB_FIRST != 0) ? r_tx_shift[DATA_W-1] : r_tx_shift[0];
  assign w_tx_shifted = (MSB_FIRST != 0) ? {r_tx_shift[DATA_W-2:0], 1'b0}
                                         : {1'b0, r_tx_shift[DATA_W-1:1]};

  // Frame FSM: command/word assembly, tx capture and registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_word_idx    <= '0;
      r_cmd_shift   <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_sdo         <= 1'b0;
      r_sdo_oe      <= 1'b0;
      r_cmd_data    <= '0;
      r_rx_data     <= '0;
      r_rx_word_cnt <= '0;
      r_cmd_valid   <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_tx_ack      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_partial_err <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_cmd_valid   <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_tx_ack      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_partial_err <= 1'b0;
      r_tx_underrun <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state    <= CMD;
            r_bit_cnt  <= '0;
            r_word_idx <= '0;
            r_sdo      <= 1'b0;
            r_sdo_oe   <= 1'b1;
          end
        end
        CMD: begin
          if (w_sample) begin
            r_cmd_shift <= w_cmd_next;
            if (w_cmd_done) begin
              r_cmd_data  <= w_cmd_next;
              r_cmd_valid <= 1'b1;
              r_bit_cnt   <= '0;
              r_state     <= DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_sample) begin
            r_rx_shift <= w_rx_next;
            if (w_word_done) begin
              r_rx_data     <= w_rx_next;
              r_rx_valid    <= 1'b1;
              r_rx_word_cnt <= r_word_idx;
              r_bit_cnt     <= '0;
              if (r_word_idx != IDX_MAX) r_word_idx <= r_word_idx + 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_shift) begin
            r_sdo      <= w_tx_bit;
            r_tx_shift <= w_tx_shifted;
          end
        end
        default: r_state <= IDLE;
      endcase

      // End of command or word: load the next tx word (zeros on underrun)
      if (w_cmd_done || w_word_done) begin
        r_tx_shift    <= tx_valid ? tx_data : '0;
        r_tx_ack      <= 1'b1;
        r_tx_underrun <= ~tx_valid;
      end

      // cs_n release wins over everything else; a word completing on the
      // same cycle has already been delivered above, so it is not partial
      if ((r_state != IDLE) && w_cs_rise) begin
        r_state       <= IDLE;
        r_bit_cnt     <= '0;
        r_sdo         <= 1'b0;
        r_sdo_oe      <= 1'b0;
        r_frame_done  <= 1'b1;
        r_partial_err <= (r_bit_cnt != '0) && !(w_cmd_done || w_word_done);
      end
    end
  end

  assign spi_sdo     = r_sdo;
  assign spi_sdo_oe  = r_sdo_oe;
  assign cmd_data    = r_cmd_data;
  assign cmd_valid   = r_cmd_valid;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_word_cnt = r_rx_word_cnt;
  assign tx_ack      = r_tx_ack;
  assign frame_done  = r_frame_done;
  assign partial_err = r_partial_err;
  assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_slave_mc.sv
// Bench for spi_slave_mc: five instances (modes 0-3 MSB-first, mode 0
// LSB-first with a 2-bit word counter) driven by a behavioural SPI master.
module tb_spi_slave_mc;

  localparam int NI   = 5;
  localparam int HALF = 8;   // sck half period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sck[NI], cs_n[NI], sdi[NI], sdo[NI], sdo_oe[NI];
  logic        cmd_valid[NI], rx_valid[NI], tx_valid[NI], tx_ack[NI];
  logic        frame_done[NI], partial_err[NI], tx_underrun[NI];
  logic [7:0]  cmd_data[NI];
  logic [31:0] rx_data[NI];
  logic [31:0] tx_data[NI];
  logic [7:0]  rx_word_cnt[NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int P_CPOL = (gi % 4) / 2;
    localparam int P_CPHA = gi % 2;
    localparam int P_MSB  = (gi < 4) ? 1 : 0;
    localparam int P_CNTW = (gi < 4) ? 8 : 2;
    logic [P_CNTW-1:0] w_cnt;
    spi_slave_mc #(
      .DATA_W(32), .CMD_W(8), .CPOL(P_CPOL), .CPHA(P_CPHA),
      .MSB_FIRST(P_MSB), .SYNC_STAGES(2), .CNT_W(P_CNTW)
    ) u_dut (
      .clk(clk), .rst(rst),
      .spi_sck(sck[gi]), .spi_cs_n(cs_n[gi]), .spi_sdi(sdi[gi]),
      .spi_sdo(sdo[gi]), .spi_sdo_oe(sdo_oe[gi]),
      .cmd_data(cmd_data[gi]), .cmd_valid(cmd_valid[gi]),
      .rx_data(rx_data[gi]), .rx_valid(rx_valid[gi]), .rx_word_cnt(w_cnt),
      .tx_data(tx_data[gi]), .tx_valid(tx_valid[gi]), .tx_ack(tx_ack[gi]),
      .frame_done(frame_done[gi]), .partial_err(partial_err[gi]),
      .tx_underrun(tx_underrun[gi])
    );
    assign rx_word_cnt[gi] = 8'(w_cnt);
  end

  // ---------------- reference configuration per instance ----------------
  function automatic bit cpol_of(input int i); return ((i % 4) / 2) != 0; endfunction
  function automatic bit cpha_of(input int i); return (i % 2) != 0; endfunction
  function automatic bit msb_of(input int i);  return i < 4; endfunction
  function automatic int cntmax_of(input int i); return (i < 4) ? 255 : 3; endfunction

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int i);
    return {8'h00, sdo[i], sdo_oe[i], cmd_data[i], cmd_valid[i], rx_data[i], rx_valid[i],
            rx_word_cnt[i], tx_ack[i], frame_done[i], partial_err[i], tx_underrun[i]};
  endfunction

  // ---------------- event monitor on the active instance ----------------
  int          act = 0;
  int          n_cmdv = 0, n_ack = 0, n_under = 0, n_ubad = 0;
  int          n_done = 0, n_perr = 0, n_pbad = 0, rx_wp = 0;
  logic [7:0]  cmd_seen = 8'h00;
  logic [31:0] rx_log[1024];
  logic [7:0]  cnt_log[1024];

  always @(negedge clk) begin
    if (cmd_valid[act]) begin
      n_cmdv   <= n_cmdv + 1;
      cmd_seen <= cmd_data[act];
    end
    if (rx_valid[act]) begin
      rx_log[rx_wp % 1024]  <= rx_data[act];
      cnt_log[rx_wp % 1024] <= rx_word_cnt[act];
      rx_wp <= rx_wp + 1;
    end
    if (tx_ack[act])                     n_ack   <= n_ack + 1;
    if (tx_underrun[act])                n_under <= n_under + 1;
    if (tx_underrun[act] && !tx_ack[act]) n_ubad <= n_ubad + 1;
    if (frame_done[act])                 n_done  <= n_done + 1;
    if (partial_err[act])                n_perr  <= n_perr + 1;
    if (partial_err[act] && !frame_done[act]) n_pbad <= n_pbad + 1;
  end

  // ---------------- behavioural SPI master ----------------
  logic [31:0] mosi_w[16];   // words the master sends
  logic [31:0] txw[16];      // words offered on tx_data, in capture order
  logic [31:0] rec_w[16];    // words the master reassembles from sdo
  logic [31:0] last_rx[NI];  // expected rx_data hold value per instance

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_frame(input int idx, input logic [7:0] cmd, input int nwords,
                           input int extra, input bit raise_cs, input bit txv);
    int total, w, k;
    logic b;
    bit cpol, cpha, msb;
    cpol  = cpol_of(idx);
    cpha  = cpha_of(idx);
    msb   = msb_of(idx);
    total = 8 + nwords * 32 + extra;
    for (int j = 0; j < 16; j++) rec_w[j] = '0;
    act          = idx;
    tx_valid[idx] = txv;
    tx_data[idx]  = txw[0];
    sck[idx]  = cpol;
    cs_n[idx] = 1'b1;
    sdi[idx]  = 1'b0;
    wait_clk(HALF);
    cs_n[idx] = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < total; i++) begin
      if (i < 8) begin
        w = -1;
        k = i;
        b = msb ? cmd[7-k] : cmd[k];
      end else begin
        w = (i - 8) / 32;
        k = (i - 8) % 32;
        b = msb ? mosi_w[w][31-k] : mosi_w[w][k];
        // mid-word: present the word that the end of this word will capture
        if (k == 16) tx_data[idx] = txw[w+1];
      end
      if (!cpha) begin
        sdi[idx] = b;
        wait_clk(HALF);
        sck[idx] = ~cpol;
        if (w >= 0) begin
          if (msb) rec_w[w][31-k] = sdo[idx];
          else     rec_w[w][k]    = sdo[idx];
        end
        wait_clk(HALF);
        sck[idx] = cpol;
      end else begin
        sck[idx] = ~cpol;
        sdi[idx] = b;
        wait_clk(HALF);
        sck[idx] = cpol;
        if (w >= 0) begin
          if (msb) rec_w[w][31-k] = sdo[idx];
          else     rec_w[w][k]    = sdo[idx];
        end
        wait_clk(HALF);
      end
    end
    wait_clk(HALF);
    if (raise_cs) begin
      cs_n[idx] = 1'b1;
      wait_clk(12);
    end
  endtask

  // One complete frame plus all checks derived from the frame description
  task automatic do_frame(input int idx, input logic [7:0] cmd, input int nwords,
                          input int extra, input bit txv);
    int s_cmdv, s_ack, s_under, s_ubad, s_done, s_perr, s_pbad, s_rx;
    int exp_acks, exp_cnt;
    s_cmdv = n_cmdv; s_ack = n_ack; s_under = n_under; s_ubad = n_ubad;
    s_done = n_done; s_perr = n_perr; s_pbad = n_pbad; s_rx = rx_wp;
    $display("[TB] frame inst=%0d cmd=%02h words=%0d extra_bits=%0d tx_valid=%0d",
             idx, cmd, nwords, extra, txv);
    spi_frame(idx, cmd, nwords, extra, 1'b1, txv);
    exp_acks = nwords + 1;
    chk("cmd_valid_cnt", 64'(n_cmdv - s_cmdv), 64'd1);
    chk("cmd_data_pulse", 64'(cmd_seen), 64'(cmd));
    chk("rx_valid_cnt", 64'(rx_wp - s_rx), 64'(nwords));
    for (int j = 0; j < nwords; j++) begin
      exp_cnt = (j < cntmax_of(idx)) ? j : cntmax_of(idx);
      chk("rx_data_word", 64'(rx_log[(s_rx + j) % 1024]), 64'(mosi_w[j]));
      chk("rx_word_cnt", 64'(cnt_log[(s_rx + j) % 1024]), 64'(exp_cnt));
      chk("miso_word", 64'(rec_w[j]), txv ? 64'(txw[j]) : 64'd0);
    end
    chk("tx_ack_cnt", 64'(n_ack - s_ack), 64'(exp_acks));
    chk("tx_underrun_cnt", 64'(n_under - s_under), txv ? 64'd0 : 64'(exp_acks));
    chk("tx_underrun_align", 64'(n_ubad - s_ubad), 64'd0);
    chk("frame_done_cnt", 64'(n_done - s_done), 64'd1);
    chk("partial_err_cnt", 64'(n_perr - s_perr), 64'(extra != 0));
    chk("partial_err_align", 64'(n_pbad - s_pbad), 64'd0);
    if (nwords > 0) last_rx[idx] = mosi_w[nwords-1];
    chk("rx_data_hold", 64'(rx_data[idx]), 64'(last_rx[idx]));
    chk("cmd_data_hold", 64'(cmd_data[idx]), 64'(cmd));
    chk("sdo_oe_after", 64'(sdo_oe[idx]), 64'd0);
  endtask

  task automatic fill_rand();
    for (int j = 0; j < 16; j++) begin
      mosi_w[j] = $urandom;
      txw[j]    = $urandom;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idx, nw, ex;
    bit txv;
    for (int i = 0; i < NI; i++) begin
      sck[i] = cpol_of(i); cs_n[i] = 1'b1; sdi[i] = 1'b0;
      tx_data[i] = '0; tx_valid[i] = 1'b0; last_rx[i] = '0;
    end
    rst = 1'b1;
    wait_clk(4);
    for (int i = 0; i < NI; i++) chk("reset_outputs", outs(i), 64'd0);
    rst = 1'b0;
    wait_clk(8);

    // Same frame in all four modes
    for (int m = 0; m < 4; m++) begin
      fill_rand();
      mosi_w[0] = 32'h12345678;
      txw[0]    = 32'hCAFEBABE;
      do_frame(m, 8'hA5, 1, 0, 1'b1);
    end

    // Burst of three words
    fill_rand();
    mosi_w[0] = 32'h1; mosi_w[1] = 32'h2; mosi_w[2] = 32'h3;
    do_frame(0, 8'h3C, 3, 0, 1'b1);

    // Frame cut 12 bits into the first word, then one into the second word
    fill_rand();
    do_frame(0, 8'h96, 0, 12, 1'b1);
    fill_rand();
    do_frame(2, 8'h69, 1, 12, 1'b1);

    // Underrun: tx_valid low for the whole frame
    fill_rand();
    do_frame(1, 8'h0F, 2, 0, 1'b0);

    // LSB-first, with the 2-bit word counter saturating
    fill_rand();
    do_frame(4, 8'h5A, 5, 0, 1'b1);

    // Randomised frames
    for (int r = 0; r < 6; r++) begin
      fill_rand();
      idx = $urandom_range(0, NI - 1);
      nw  = $urandom_range(1, 3);
      ex  = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 31) : 0;
      txv = $urandom_range(0, 3) != 0;
      do_frame(idx, 8'($urandom), nw, ex, txv);
    end

    // Reset in the middle of a word, cs_n still low
    fill_rand();
    $display("[TB] frame inst=0 aborted by reset after 18 data bits");
    spi_frame(0, 8'hC3, 0, 18, 1'b0, 1'b1);
    chk("sdo_oe_mid_frame", 64'(sdo_oe[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("reset_mid_frame", outs(0), 64'd0);
    wait_clk(3);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) last_rx[i] = '0;
    wait_clk(10);
    chk("idle_after_reset", outs(0), 64'd0);
    cs_n[0] = 1'b1;
    wait_clk(10);
    fill_rand();
    do_frame(0, 8'hE7, 2, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net: everything above is bounded, this only trips on a hang
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/spi_slave_mc.md
Name: spi_slave_mc

Overview:
Parametrised SPI slave, successor to the dual-chip-select cmd/data SPI block. It uses a single active-low chip select per frame: CMD_W command bits, then a burst of DATA_W-bit data words. All four CPOL/CPHA modes and MSB/LSB-first ordering are supported. Per-word rx/tx handshakes and error flags are provided. It sits between the MCU SPI pins and the register/DDS control logic in the clk domain.

Parameters:
DATA_W, 32, data word width (>=2)
CMD_W, 8, command width (>=2)
CPOL, 0, sck idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB first on sdi and sdo; 0 = LSB first
SYNC_STAGES, 2, synchroniser depth for sck, cs_n and sdi (>=2)
CNT_W, 8, width of the burst word counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
spi_sck  in  1  SPI clock (async, <= clk/8)
spi_cs_n  in  1  frame select, active-low
spi_sdi  in  1  MCU -> FPGA data
spi_sdo  out  1  FPGA -> MCU data
spi_sdo_oe  out  1  sdo output enable (high while frame active)
cmd_data  out  CMD_W  last received command
cmd_valid  out  1  1-cycle pulse, cmd_data updated
rx_data  out  DATA_W  last received word
rx_valid  out  1  1-cycle pulse, rx_data updated
rx_word_cnt  out  CNT_W  index of the word in rx_data within the frame (0-based)
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data is valid
tx_ack  out  1  1-cycle pulse, tx_data captured
frame_done  out  1  1-cycle pulse on frame end (cs_n rise)
partial_err  out  1  1-cycle pulse, frame ended mid-word/mid-command
tx_underrun  out  1  1-cycle pulse, capture happened with tx_valid low

Behaviour:
- Reset: all outputs 0 (spi_sdo 0, spi_sdo_oe 0), state IDLE, shift registers and counters 0.
- Sync: sck, cs_n and sdi each pass through SYNC_STAGES flops. Edges are detected on the last two synced sck stages.
- Edge roles: sample edge is rising when CPOL==CPHA, otherwise falling. The shift edge is the opposite edge.
- A sample edge takes the synced sdi bit aligned with that edge.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on synced cs_n falling edge. Bit counter cleared; spi_sdo_oe set next cycle.
  - CMD: shift on sample edges. Shift edges are ignored and spi_sdo is held at 0.
  - After CMD_W sample edges: cmd_data registered, cmd_valid pulses the following cycle, and the state moves to DATA.
  - On that same cycle tx_data is captured into the tx shift register and tx_ack pulses.
  - DATA: each shift edge drives the next tx bit onto spi_sdo; the first shift edge after capture drives the first bit. Each sample edge shifts one rx bit in.
  - After DATA_W sample edges: rx_data registered, rx_valid pulses the next cycle, rx_word_cnt is set to the current word index, and the next tx word is captured with tx_ack.
  - Word index saturates at 2^CNT_W-1.
- Any state -> IDLE on synced cs_n rising edge. frame_done pulses and spi_sdo_oe clears.
  - If the bit counter is nonzero (incomplete command or word), partial_err pulses in the same cycle as frame_done.
  - The partial word is discarded: no rx_valid, and rx_data/cmd_data are unchanged.
- Underrun: if tx_valid is low at a capture, an all-zero word is loaded, tx_ack still pulses, and tx_underrun pulses in the same cycle as tx_ack.
- Word end coinciding with cs_n rise in the same cycle: complete the word first (rx_valid), then frame_done; partial_err is not asserted.
- Sample edges in IDLE are ignored. cmd_data and rx_data hold their values between frames.
- Asynchronous reset mid-frame returns to IDLE immediately. The next frame requires a fresh cs_n falling edge.
- Latency: sdi pin to rx_valid is SYNC_STAGES+2 clk after the final sample edge.

Decomposition:
- Package spi_pkg holds:
  - FSM state encoding (IDLE, CMD, DATA);
  - a function returning the sample edge polarity from CPOL/CPHA;
  - a bit-counter width helper, clog2 of max(CMD_W, DATA_W).
- Sub-module spi_sync_edge (parameter SYNC_STAGES) provides synchroniser, rise and fall pulses. It is instantiated for sck and cs_n; sdi uses the synchroniser only.

Test Plan:
- Mode 0, MSB first: frame of cmd 0xA5 then word 0x12345678, tx_data 0xCAFEBABE, tx_valid high -> cmd_valid with 0xA5; rx_valid with 0x12345678 and rx_word_cnt 0; MCU captures 0xCAFEBABE; frame_done, no partial_err.
- Modes 1/2/3: same frame -> identical cmd, rx and sdo results.
- Burst of 3 words 0x1, 0x2, 0x3 -> three rx_valid pulses with rx_word_cnt 0, 1, 2; four tx_ack pulses in total (the last one at the end of word 3).
- cs_n raised after cmd plus 12 data bits -> frame_done and partial_err in the same cycle, no second rx_valid, rx_data unchanged.
- tx_valid held low -> MCU receives 0x00000000; tx_underrun and tx_ack pulse together.
- MSB_FIRST=0: sdi 0x5A sent LSB first -> cmd_data 0x5A.
- Assert rst mid-word -> all outputs 0 within the reset cycle; the next full frame decodes correctly.
